// File: rtl/data_ram_ctrl_pkg.sv
// Shared types and address helpers for the data RAM controller.
// Feature macro used by the top: DATA_RAM_INIT_INDEX_EN.
package data_ram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_t;

    // Widest byte address the helpers accept; callers zero-extend into this.
    localparam int unsigned MAX_ADDR_W = 64;

    function automatic logic [MAX_ADDR_W-1:0] word_index(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           lane_bits
    );
        return addr >> lane_bits;
    endfunction

    function automatic logic addr_err(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           lane_bits,
        input int unsigned           idx_bits
    );
        logic [MAX_ADDR_W-1:0] lane_mask;
        lane_mask = (MAX_ADDR_W'(1) << lane_bits) - MAX_ADDR_W'(1);
        return ((addr & lane_mask) != '0) || ((addr >> (lane_bits + idx_bits)) != '0);
    endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Request/response bus between the load/store stage and the data RAM controller.
interface data_ram_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    localparam int NB = DATA_W / 8;

    // Both channels: a transfer happens on a clock edge where valid && ready;
    // the sender must not depend on ready to raise valid.
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [NB-1:0]     req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_ram_ctrl_ram_byte_array.sv
// DEPTH x DATA_W word store with a byte-enabled write port and a registered read port.
module ram_byte_array #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int NB     = DATA_W / 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [NB-1:0]     be_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: post-reset init sweep, address checking, single-entry response register.
// DATA_RAM_INIT_INDEX_EN selects word[i] = i as the sweep value instead of zero.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    data_ram_ctrl_if.slave bus,
    output logic          init_done,
    output ram_state_t    dbg_state_o
);
    localparam int NB        = DATA_W / 8;
    localparam int AW        = $clog2(DEPTH);
    localparam int LANE_BITS = $clog2(NB);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    ram_state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic resp_valid_q, resp_valid_d;
    logic resp_err_q, resp_err_d;
    logic rd_ok_q, rd_ok_d;

    logic [MAX_ADDR_W-1:0] addr_ext;
    logic [MAX_ADDR_W-1:0] word_full;
    logic [AW-1:0]         req_idx;
    logic                  req_err;
    logic                  req_ready;
    logic                  accept;
    logic                  unused_idx_bits;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] init_word;

    assign addr_ext        = MAX_ADDR_W'(bus.req_addr);
    assign word_full       = word_index(addr_ext, LANE_BITS);
    assign req_idx         = word_full[AW-1:0];
    assign unused_idx_bits = ^word_full[MAX_ADDR_W-1:AW];
    assign req_err         = addr_err(addr_ext, LANE_BITS, AW);

    // A stalled response blocks new requests so its data stays intact.
    assign req_ready = (state_q == ST_RUN) && (!resp_valid_q || bus.resp_ready);
    assign accept    = bus.req_valid && req_ready;

`ifdef DATA_RAM_INIT_INDEX_EN
    assign init_word = DATA_W'(cnt_q);
`else
    assign init_word = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rd_ok_q      <= rd_ok_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        rd_ok_d      = rd_ok_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = req_err;
                    rd_ok_d      = !bus.req_we && !req_err;
                end else if (resp_valid_q && bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    rd_ok_d      = 1'b0;
                end
            end
        endcase
    end

    // The sweep owns the write port until RUN; no request can be accepted meanwhile.
    always_comb begin
        mem_we    = accept && bus.req_we && !req_err;
        mem_waddr = req_idx;
        mem_wdata = bus.req_wdata;
        mem_be    = bus.req_be;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = init_word;
            mem_be    = '1;
        end
    end

    assign mem_re = accept && !bus.req_we && !req_err;

    ram_byte_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk    (clk),
        .we_i   (mem_we),
        .waddr_i(mem_waddr),
        .wdata_i(mem_wdata),
        .be_i   (mem_be),
        .re_i   (mem_re),
        .raddr_i(req_idx),
        .rdata_o(mem_rdata)
    );

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rd_ok_q ? mem_rdata : '0;
    assign init_done      = (state_q == ST_RUN);
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl: directed scenarios plus randomized traffic against a word-array model.
module tb_data_ram_ctrl;
    import data_ram_ctrl_pkg::*;

    parameter int DATA_W = 32;
    parameter int DEPTH  = 32;
    parameter int ADDR_W = 32;
    localparam int NB = DATA_W / 8;
    localparam int W  = DATA_W + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_done;
    ram_state_t dbg_state;

    data_ram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_ram_ctrl #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .init_done  (init_done),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: plain word array plus expected {err, rdata} per accepted request.
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [W-1:0]      exp_q[$];
    int                n_cmp  = 0;
    int                n_fail = 0;
    int                n_resp = 0;
    logic              acc_seen;
    logic [DATA_W-1:0] last_rdata;
    logic              last_err;

    localparam logic [DATA_W-1:0] WORD_DEAD = DATA_W'(32'hDEADBEEF);
    localparam logic [DATA_W-1:0] WORD_BEAA = DATA_W'(32'hDEADBEAA);

    function automatic logic [DATA_W-1:0] init_val(input int i);
`ifdef DATA_RAM_INIT_INDEX_EN
        return DATA_W'(i);
`else
        return DATA_W'(0 * i);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_val(i);
    endtask

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic tick();
        logic [W-1:0]      e;
        logic [DATA_W-1:0] word;
        longint unsigned   a;
        longint unsigned   w;
        int                wi;
        @(negedge clk);
        acc_seen = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            model_reset();
        end else begin
            if (bus.resp_valid && bus.resp_ready) begin
                n_resp++;
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_err;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: got err=%b rdata=%h, required no response",
                             bus.resp_err, bus.resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.resp_err, bus.resp_rdata} !== e) begin
                        n_fail++;
                        $display("FAIL resp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                                 bus.resp_err, bus.resp_rdata, e[W-1], e[DATA_W-1:0]);
                    end
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_seen = 1'b1;
                a = 64'(bus.req_addr);
                w = a / NB;
                if ((a % NB) != 0 || w >= DEPTH) begin
                    e = {1'b1, {DATA_W{1'b0}}};
                end else begin
                    wi = int'(w);
                    if (bus.req_we) begin
                        word = model_mem[wi];
                        for (int b = 0; b < NB; b++)
                            if (bus.req_be[b]) word[8*b +: 8] = bus.req_wdata[8*b +: 8];
                        model_mem[wi] = word;
                        e = {1'b0, {DATA_W{1'b0}}};
                    end else begin
                        e = {1'b0, model_mem[wi]};
                    end
                end
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [NB-1:0] be);
        int k;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.req_valid = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!acc_seen && k < 50);
        if (!acc_seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", k);
        end
    endtask

    task automatic drain();
        int k;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        k = 0;
        while (bus.resp_valid && k < 8) begin
            tick();
            k++;
        end
        n_cmp++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got resp_valid=%b, required 0", bus.resp_valid);
        end
    endtask

    task automatic run_sweep();
        int   cycles;
        logic ready_seen;
        rst_n         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        cycles        = 0;
        ready_seen    = 1'b0;
        while (!init_done && cycles < DEPTH + 8) begin
            if (bus.req_ready) ready_seen = 1'b1;
            tick();
            cycles++;
        end
        bus.req_valid = 1'b0;
        n_cmp++;
        if (cycles != DEPTH) begin
            n_fail++;
            $display("FAIL sweep_len: got %0d cycles, required %0d", cycles, DEPTH);
        end
        n_cmp++;
        if (ready_seen || dbg_state !== ST_RUN) begin
            n_fail++;
            $display("FAIL sweep_ready: got ready_seen=%b state=%0d, required 0 and %0d",
                     ready_seen, dbg_state, ST_RUN);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.resp_valid, bus.req_ready, init_done, bus.resp_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got valid/ready/done/err=%b%b%b%b, required 0000",
                     bus.resp_valid, bus.req_ready, init_done, bus.resp_err);
        end
        n_cmp++;
        if (bus.resp_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h, required 0", bus.resp_rdata);
        end
        run_sweep();
    endtask

    task automatic test_init_contents();
        send(1'b0, ADDR_W'(5 * NB), '0, '0);
        drain();
        n_cmp++;
        if ({last_err, last_rdata} !== {1'b0, init_val(5)}) begin
            n_fail++;
            $display("FAIL init_word5: got err=%b rdata=%h, required err=0 rdata=%h",
                     last_err, last_rdata, init_val(5));
        end
    endtask

    task automatic test_write_read();
        int n0;
        n0 = n_resp;
        send(1'b1, ADDR_W'(2 * NB), WORD_DEAD, '1);
        send(1'b0, ADDR_W'(2 * NB), '0, '0);
        drain();
        n_cmp++;
        if ({last_err, last_rdata} !== {1'b0, WORD_DEAD} || n_resp - n0 != 2) begin
            n_fail++;
            $display("FAIL write_read: got err=%b rdata=%h resps=%0d, required err=0 rdata=%h resps=2",
                     last_err, last_rdata, n_resp - n0, WORD_DEAD);
        end
    endtask

    task automatic test_partial();
        send(1'b1, ADDR_W'(2 * NB), DATA_W'(32'h000000AA), NB'(1));
        send(1'b0, ADDR_W'(2 * NB), '0, '0);
        drain();
        n_cmp++;
        if (last_rdata !== WORD_BEAA) begin
            n_fail++;
            $display("FAIL partial_merge: got %h, required %h", last_rdata, WORD_BEAA);
        end
    endtask

    task automatic test_errors();
        logic [ADDR_W-1:0] bad [3];
        bad[0] = ADDR_W'(6);
        bad[1] = ADDR_W'(DEPTH * NB);
        bad[2] = ADDR_W'(2 * NB + 1);
        for (int i = 0; i < 3; i++) begin
            send(i == 2, bad[i], '1, '1);
            drain();
            n_cmp++;
            if ({last_err, last_rdata} !== {1'b1, {DATA_W{1'b0}}}) begin
                n_fail++;
                $display("FAIL addr_err_%0d: got err=%b rdata=%h, required err=1 rdata=0",
                         i, last_err, last_rdata);
            end
        end
        send(1'b0, ADDR_W'(2 * NB), '0, '0);
        drain();
        n_cmp++;
        if (last_rdata !== WORD_BEAA) begin
            n_fail++;
            $display("FAIL err_no_write: got %h, required %h", last_rdata, WORD_BEAA);
        end
    endtask

    task automatic test_backpressure();
        bus.resp_ready = 1'b0;
        send(1'b0, ADDR_W'(2 * NB), '0, '0);
        bus.req_addr = ADDR_W'(5 * NB);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 ||
                bus.resp_rdata !== WORD_BEAA || acc_seen) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got ready=%b valid=%b rdata=%h acc=%b, required 0 1 %h 0",
                         i, bus.req_ready, bus.resp_valid, bus.resp_rdata, acc_seen, WORD_BEAA);
            end
        end
        bus.resp_ready = 1'b1;
        tick();
        n_cmp++;
        if (!acc_seen || bus.resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got acc=%b valid=%b, required 1 1", acc_seen, bus.resp_valid);
        end
        drain();
        n_cmp++;
        if (last_rdata !== init_val(5)) begin
            n_fail++;
            $display("FAIL bp_second: got %h, required %h", last_rdata, init_val(5));
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] wd;
        logic [NB-1:0]     be;
        int                sel;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_we    = 1'($urandom_range(0, 1));
            if (sel == 0)
                bus.req_addr = ADDR_W'($urandom());
            else if (sel == 1 && NB > 1)
                bus.req_addr = ADDR_W'($urandom_range(0, DEPTH - 1) * NB + $urandom_range(1, NB - 1));
            else if (sel < 6)
                bus.req_addr = ADDR_W'($urandom_range(0, 3) * NB);
            else
                bus.req_addr = ADDR_W'($urandom_range(0, DEPTH - 1) * NB);
            for (int b = 0; b < NB; b++) begin
                wd[8*b +: 8] = 8'($urandom_range(0, 255));
                be[b]        = 1'($urandom_range(0, 1));
            end
            bus.req_wdata  = wd;
            bus.req_be     = be;
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bus.resp_ready = 1'b0;
        send(1'b0, ADDR_W'(0), '0, '0);
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got resp_valid=%b, required 1", bus.resp_valid);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({bus.resp_valid, init_done, bus.req_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset: got valid/done/ready=%b%b%b, required 000",
                     bus.resp_valid, init_done, bus.req_ready);
        end
        bus.resp_ready = 1'b1;
        run_sweep();
        send(1'b0, ADDR_W'(2 * NB), '0, '0);
        drain();
        n_cmp++;
        if (last_rdata !== init_val(2)) begin
            n_fail++;
            $display("FAIL mid_reswept: got %h, required %h", last_rdata, init_val(2));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_be     = '0;
        bus.resp_ready = 1'b1;
        model_reset();
        test_reset();
        test_init_contents();
        test_write_read();
        test_partial();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_resp: got %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
